// File: rtl/load_store_unit.sv
// Load/store front end for a word-addressed data memory: it formats byte, halfword and word
// requests into memory strobes and masks, and aligns load data back into the response.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rstrb_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [3:0]        mem_wmask_o,
    output logic [31:0]       mem_wdata_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic        req_err;
    logic        accept;
    logic [31:0] store_wdata;
    logic [3:0]  store_mask;
    logic [31:0] load_shifted;
    logic [31:0] load_data;

    always_comb begin
        req_illegal = 1'b1;
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
            3'b100, 3'b101:         req_illegal = req_we_i;
            default:                req_illegal = 1'b1;
        endcase
        req_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                         ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        req_err = req_illegal || req_misaligned;
        accept  = (state_q == IDLE) && req_valid_i;

        case (req_funct3_i[1:0])
            2'b00:   store_wdata = {4{req_wdata_i[7:0]}};
            2'b01:   store_wdata = {2{req_wdata_i[15:0]}};
            default: store_wdata = req_wdata_i;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   store_mask = 4'b0001 << off_q;
            2'b01:   store_mask = 4'b0011 << {off_q[1], 1'b0};
            default: store_mask = 4'b1111;
        endcase

        load_shifted = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_data = {24'd0, load_shifted[7:0]};
            3'b101:  load_data = {16'd0, load_shifted[15:0]};
            default: load_data = load_shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = req_err ? RESP : ISSUE;
            ISSUE:   state_d = we_q ? RESP : RD_WAIT;
            RD_WAIT: state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobe and mask are gated by rst_n so nothing reaches memory while reset is held.
    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
        mem_rstrb_o = rst_n && (state_q == ISSUE) && !we_q;
        mem_wmask_o = (rst_n && (state_q == ISSUE) && we_q) ? store_mask : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            if (accept) begin
                we_q        <= req_we_i;
                funct3_q    <= req_funct3_i;
                off_q       <= req_addr_i[1:0];
                rsp_err_q   <= req_err;
                rsp_rdata_q <= 32'd0;
                // Erroneous requests never touch the memory-side registers.
                if (!req_err) begin
                    mem_addr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
                    if (req_we_i) begin
                        mem_wdata_q <= store_wdata;
                    end
                end
            end
            if (state_q == RD_WAIT) begin
                rsp_rdata_q <= load_data;
            end
        end
    end

    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
